dmem_arbiter: RTL and testbench

//  Shares the single-port, byte-addressed, big-endian 16-bit data memory between
//  two requesters: port 0 = CPU load/store unit, port 1 = debug/DMA loader.

---
 rtl/dmem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port, byte-addressed, big-endian 16-bit data memory between
// port 0 (CPU load/store unit) and port 1 (debug/DMA loader). Each access runs
// IDLE -> ACCESS -> RESP, so the winner sees ack two cycles after its request
// is sampled, and at most one access completes every three cycles.
// Optional feature: define DMEM_ARB_RR_EN for round-robin conflict resolution;
// without it, port 0 always wins a conflict.
module dmem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_BYTES = 128
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we1,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_adresa,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [DATA_W-1:0] mem_ReadData,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Highest byte address whose word still fits entirely inside the memory.
  localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(MEM_BYTES - 2);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              port_q, port_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              grant_s;
  logic              in_range_s;
  logic              access_s;
  logic [DATA_W-1:0] rd_val_s;

  assign in_range_s = (addr_q <= LAST_WORD_ADDR);
  assign access_s   = (state_q == ST_ACCESS);

`ifdef DMEM_ARB_RR_EN
  logic last_gnt_q, last_gnt_d;

  // Remember the most recent grant so the next conflict favours the other port.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if ((state_q == ST_IDLE) && (req0 || req1)) begin
      last_gnt_d = grant_s;
    end else begin
      last_gnt_d = last_gnt_q;
    end
  end

  // Round-robin history register; after reset port 1 counts as last served.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  // Choose the port to serve when at least one request is present.
  always_comb begin
    grant_s = 1'b0;
    if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
      grant_s = ~last_gnt_q;
`else
      grant_s = 1'b0;
`endif
    end else if (req1) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Sequence one access: latch the request, run the memory cycle, then respond.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    port_d   = port_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    // Out-of-range accesses and writes never take data from the memory.
    rd_val_s = (!we_q && in_range_s) ? mem_ReadData : {DATA_W{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d = ST_ACCESS;
          port_d  = grant_s;
          addr_d  = grant_s ? addr1  : addr0;
          wdata_d = grant_s ? wdata1 : wdata0;
          we_d    = grant_s ? we1    : we0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // Response flops load here so ack/err/rdata are visible in RESP.
        state_d = ST_RESP;
        if (port_q) begin
          ack1_d = 1'b1;
          err1_d = ~in_range_s;
          if (!we_q || !in_range_s) begin
            rdata1_d = rd_val_s;
          end else begin
            rdata1_d = rdata1_q;
          end
        end else begin
          ack0_d = 1'b1;
          err0_d = ~in_range_s;
          if (!we_q || !in_range_s) begin
            rdata0_d = rd_val_s;
          end else begin
            rdata0_d = rdata0_q;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and response registers; reset abandons any access in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      we_q     <= 1'b0;
      port_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= {DATA_W{1'b0}};
      rdata1_q <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      port_q   <= port_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Memory strobes are decoded from registered state; Reset gates the write
  // combinationally so a write caught in ACCESS never reaches the memory.
  assign mem_adresa   = access_s ? addr_q  : {ADDR_W{1'b0}};
  assign mem_WD       = access_s ? wdata_q : {DATA_W{1'b0}};
  assign mem_MemWrite = access_s & we_q & in_range_s & ~Reset;
  assign mem_MemRead  = access_s & ~we_q & in_range_s;
  assign busy         = (state_q != ST_IDLE);

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign err0   = err0_q;
  assign err1   = err1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed cases plus randomized two-port traffic against a transaction-level
// model of the arbiter and a shadow copy of the memory image.
// Honours DMEM_ARB_RR_EN the same way the design does.
`timescale 1ns/1ps
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int MEM_BYTES = 128;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  req_s;
  logic [15:0] addr_s [2];
  logic [15:0] wdata_s [2];
  logic [1:0]  we_s;
  logic        ack0, ack1, err0, err1, busy;
  logic [15:0] rdata0, rdata1;
  logic [15:0] mem_adresa, mem_WD, mem_ReadData;
  logic        mem_MemWrite, mem_MemRead;

  int n_checks = 0;
  int n_fail   = 0;
  int mw_cnt   = 0;

  always #5 Clk = ~Clk;

  dmem_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req_s[0]), .addr0(addr_s[0]), .wdata0(wdata_s[0]), .we0(we_s[0]),
    .req1(req_s[1]), .addr1(addr_s[1]), .wdata1(wdata_s[1]), .we1(we_s[1]),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .mem_adresa(mem_adresa), .mem_WD(mem_WD), .mem_MemWrite(mem_MemWrite),
    .mem_MemRead(mem_MemRead), .mem_ReadData(mem_ReadData), .busy(busy)
  );

  // Big-endian byte memory with combinational read; junk outside the array.
  logic [7:0] mem_b [MEM_BYTES] = '{default: 8'h00};
  assign mem_ReadData = (mem_adresa <= 16'd126) ?
                        {mem_b[mem_adresa[6:0]], mem_b[mem_adresa[6:0] + 7'd1]} : 16'hDEAD;

  // Memory write port.
  always @(posedge Clk) begin
    if (mem_MemWrite && mem_adresa <= 16'd126) begin
      mem_b[mem_adresa[6:0]]        <= mem_WD[15:8];
      mem_b[mem_adresa[6:0] + 7'd1] <= mem_WD[7:0];
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit in_rng(input logic [15:0] a);
    return int'(a) + 2 <= MEM_BYTES;
  endfunction

  // Transaction-level reference: phase counts cycles left in an access.
  int          m_phase = 0;
  int          m_port  = 0;
  logic [15:0] m_addr  = 16'h0000;
  logic [15:0] m_wd    = 16'h0000;
  logic        m_we    = 1'b0;
  logic        m_last  = 1'b1;
  logic [1:0]  m_ack   = 2'b00;
  logic [1:0]  m_err   = 2'b00;
  logic [15:0] m_rd [2] = '{16'h0000, 16'h0000};
  logic [7:0]  shadow [MEM_BYTES] = '{default: 8'h00};

  // Advance the model on each edge, then compare every DUT output to it.
  always @(posedge Clk) begin
    int a;
    int bad;
    bit acc;
    #1;
    if (Reset) begin
      m_phase = 0; m_ack = 2'b00; m_err = 2'b00;
      m_rd[0] = 16'h0000; m_rd[1] = 16'h0000; m_last = 1'b1;
    end else begin
      m_ack = 2'b00; m_err = 2'b00;
      if (m_phase == 0) begin
        if (req_s != 2'b00) begin
          if (req_s == 2'b11) m_port = (RR && !m_last) ? 1 : 0;
          else                m_port = req_s[1] ? 1 : 0;
          m_addr = addr_s[m_port]; m_wd = wdata_s[m_port]; m_we = we_s[m_port];
          m_last = (m_port == 1);
          m_phase = 2;
        end
      end else if (m_phase == 2) begin
        m_phase = 1;
        m_ack[m_port] = 1'b1;
        m_err[m_port] = !in_rng(m_addr);
        a = int'(m_addr);
        if (!in_rng(m_addr)) m_rd[m_port] = 16'h0000;
        else if (!m_we)      m_rd[m_port] = {shadow[a], shadow[a + 1]};
        else begin
          shadow[a]     = m_wd[15:8];
          shadow[a + 1] = m_wd[7:0];
        end
      end else begin
        m_phase = 0;
      end
    end
    acc = (m_phase == 2);
    chk("busy",   busy,   m_phase != 0);
    chk("ack0",   ack0,   m_ack[0]);
    chk("ack1",   ack1,   m_ack[1]);
    chk("err0",   err0,   m_err[0]);
    chk("err1",   err1,   m_err[1]);
    chk("rdata0", rdata0, m_rd[0]);
    chk("rdata1", rdata1, m_rd[1]);
    chk("mem_adresa",   mem_adresa,   acc ? m_addr : 16'h0000);
    chk("mem_WD",       mem_WD,       acc ? m_wd   : 16'h0000);
    chk("mem_MemRead",  mem_MemRead,  acc && !m_we && in_rng(m_addr));
    chk("mem_MemWrite", mem_MemWrite, acc && m_we && in_rng(m_addr) && !Reset);
    if (mem_MemWrite) mw_cnt++;
    bad = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem_b[i] !== shadow[i]) bad++;
    chk("mem_image", bad, 0);
  end

  // One request on port p from an idle arbiter; returns latency in cycles.
  task automatic txn(input int p, input logic [15:0] a, input logic w, input logic [15:0] d,
                     output int lat, output logic [15:0] rd, output logic er);
    int c;
    addr_s[p] = a; wdata_s[p] = d; we_s[p] = w; req_s[p] = 1'b1;
    lat = 0; rd = 16'h0000; er = 1'b0; c = 0;
    while (lat == 0 && c < 20) begin
      @(negedge Clk);
      c++;
      if ((p == 0 && ack0) || (p == 1 && ack1)) begin
        lat = c; rd = (p == 1) ? rdata1 : rdata0; er = (p == 1) ? err1 : err0;
      end
    end
    req_s[p] = 1'b0;
    chk("txn_ack_seen", lat != 0, 1);
    @(negedge Clk);
  endtask

  function automatic logic [15:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5)      return 16'($urandom_range(0, 15));
    else if (r < 8) return 16'($urandom_range(120, 127));
    else if (r == 8) return 16'($urandom);
    else            return 16'($urandom_range(124, 129));
  endfunction

  initial begin
    int lat;
    int mw0;
    int nack;
    logic [15:0] rd;
    logic er;
    logic [3:0] seq;
    logic saw1;
    int ack_at[$];
    logic busy_hist [40];

    Reset = 1'b1; req_s = 2'b00; we_s = 2'b00;
    addr_s[0] = 16'h0000; addr_s[1] = 16'h0000;
    wdata_s[0] = 16'h0000; wdata_s[1] = 16'h0000;
    repeat (3) @(negedge Clk);
    chk("reset_busy", busy, 0);
    chk("reset_rdata0", rdata0, 16'h0000);
    Reset = 1'b0;
    @(negedge Clk);

    // Conflict: both ports held high for four accesses.
    addr_s[0] = 16'h0002; addr_s[1] = 16'h0006; we_s = 2'b00; req_s = 2'b11;
    nack = 0; seq = 4'b0000; saw1 = 1'b0;
    for (int c = 0; c < 60 && nack < 4; c++) begin
      @(negedge Clk);
      if (ack1) saw1 = 1'b1;
      if (ack0 || ack1) begin
        seq = {seq[2:0], ack1};
        nack++;
      end
    end
    req_s = 2'b00;
    chk("t3_ack_count", nack, 4);
    chk("t3_grant_order", seq, RR ? 4'b0101 : 4'b0000);
    chk("t3_ack1_seen", saw1, RR ? 1'b1 : 1'b0);
    @(negedge Clk);

    // Port 1 write, exactly one write strobe, then read back.
    mw0 = mw_cnt;
    txn(1, 16'h0010, 1'b1, 16'h1234, lat, rd, er);
    chk("t2_write_strobes", mw_cnt - mw0, 1);
    chk("t2_latency", lat, 2);
    txn(0, 16'h0010, 1'b0, 16'h0000, lat, rd, er);
    chk("t2_read_word", rd, 16'h1234);
    txn(0, 16'h0011, 1'b0, 16'h0000, lat, rd, er);
    chk("t2_read_odd_msb", rd[15:8], 8'h34);

    // Load bytes 4/5 then read them big-endian.
    txn(1, 16'h0004, 1'b1, 16'hABCD, lat, rd, er);
    txn(0, 16'h0004, 1'b0, 16'h0000, lat, rd, er);
    chk("t1_latency", lat, 2);
    chk("t1_rdata", rd, 16'hABCD);
    chk("t1_err", er, 1'b0);

    // Last legal word, then one byte past it.
    txn(1, 16'h007E, 1'b1, 16'hBEEF, lat, rd, er);
    txn(0, 16'h007E, 1'b0, 16'h0000, lat, rd, er);
    chk("edge_7e_rdata", rd, 16'hBEEF);
    chk("edge_7e_err", er, 1'b0);
    mw0 = mw_cnt;
    txn(0, 16'h007F, 1'b1, 16'h5555, lat, rd, er);
    chk("t4_no_write", mw_cnt - mw0, 0);
    chk("t4_err", er, 1'b1);
    chk("t4_rdata", rd, 16'h0000);
    chk("t4_byte_7e", mem_b[126], 8'hBE);

    // Reset while a write sits in ACCESS.
    txn(0, 16'h0020, 1'b1, 16'h1111, lat, rd, er);
    addr_s[0] = 16'h0020; wdata_s[0] = 16'h5A5A; we_s[0] = 1'b1; req_s[0] = 1'b1;
    @(negedge Clk);
    chk("t5_in_access", mem_MemWrite, 1'b1);
    Reset = 1'b1;
    @(negedge Clk);
    chk("t5_busy_after", busy, 1'b0);
    chk("t5_no_ack", ack0, 1'b0);
    Reset = 1'b0; req_s[0] = 1'b0;
    @(negedge Clk);
    chk("t5_still_no_ack", ack0, 1'b0);
    chk("t5_mem_kept", {mem_b[32], mem_b[33]}, 16'h1111);

    // Back-to-back reads with req held.
    addr_s[0] = 16'h0000; we_s[0] = 1'b0; req_s[0] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk);
      busy_hist[c] = busy;
      if (ack0) ack_at.push_back(c);
    end
    req_s[0] = 1'b0;
    @(negedge Clk);
    chk("t6_ack_count", ack_at.size() >= 4, 1);
    chk("t6_first_ack", ack_at.size() > 0 ? ack_at[0] : -1, 1);
    for (int k = 1; k < ack_at.size() && k < 5; k++) begin
      chk("t6_gap", ack_at[k] - ack_at[k - 1], 3);
      chk("t6_idle_between", busy_hist[ack_at[k - 1] + 1], 1'b0);
    end

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge Clk);
      if (Reset) Reset = 1'b0;
      else if ($urandom_range(0, 79) == 0) Reset = 1'b1;
      for (int p = 0; p < 2; p++) begin
        if (req_s[p] && ((p == 0) ? ack0 : ack1)) begin
          if ($urandom_range(0, 3) == 0) begin
            addr_s[p] = rand_addr(); wdata_s[p] = 16'($urandom); we_s[p] = 1'($urandom);
          end else begin
            req_s[p] = 1'b0;
          end
        end else if (!req_s[p] && $urandom_range(0, 2) == 0) begin
          addr_s[p] = rand_addr(); wdata_s[p] = 16'($urandom); we_s[p] = 1'($urandom);
          req_s[p] = 1'b1;
        end
      end
    end
    Reset = 1'b0; req_s = 2'b00;
    repeat (5) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
